muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the EX-stage ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exports busy_o so the hazard unit can stall dependent MFHI/MFLO and any new mul/div op.
- Successor to the single-cycle ALU path: generalised in width, multi-cycle, and flushable.

Parameters:
- XLEN, 32, operand/HI/LO width; any value >= 4.
- CNT_W, $clog2(XLEN+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  issue request for op_i, sampled at the clock edge.
- op_i  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- a_i  in  XLEN  rs operand: dividend, multiplicand, or MTHI/MTLO data.
- b_i  in  XLEN  rt operand: divisor or multiplier.
- flush_i  in  1  abort the in-flight op (branch or flush from the hazard unit).
- busy_o  out  1  registered; high while an op is in flight.
- done_o  out  1  registered one-cycle pulse when HI/LO are updated by a mul/div.
- hi_o  out  XLEN  HI register.
- lo_o  out  XLEN  LO register.

Behaviour:
- Reset: at an edge with rst=1, state=IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, counter=0. Reset overrides everything, including mid-operation.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start_i=1, flush_i=0:
  - op 0/1: latch operand magnitudes (absolute values for signed ops) and sign flags, cnt=0, go to MUL, busy_o=1.
  - op 2/3: same latching, go to DIV, busy_o=1.
  - op 4/5: write hi_o/lo_o from a_i at this edge; stay in IDLE; busy_o stays 0; no done_o.
  - op 6/7: ignored.
- MUL: one radix-2 shift-add step per edge on a 2*XLEN accumulator; cnt increments; at cnt==XLEN-1 go to FIX.
- DIV: one restoring shift-subtract step per edge; quotient and remainder are unsigned magnitudes; cnt==XLEN-1 goes to FIX.
- FIX, one edge:
  - Signed MULT: negate the 2*XLEN product if the operand signs differ.
  - Signed DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI (product high half or remainder) and LO (product low half or quotient).
  - Set done_o=1 for the next cycle only, busy_o=0, state=IDLE.
- Latency: start sampled at edge 0, HI/LO written at edge XLEN+1. busy_o is high for XLEN+1 cycles. done_o is high in the cycle after edge XLEN+1.
- Divide by zero: the DIV state is bypassed. At the next edge, HI=a_i, LO=all-ones (signed and unsigned), done_o pulses. Latency is 1.
- Signed overflow (most-negative / -1): LO=most-negative, HI=0. This falls out of the magnitude algorithm; no special case is needed.
- start_i while busy_o=1: ignored, including MTHI/MTLO. The hazard unit is responsible for stalling.
- flush_i=1 in MUL, DIV or FIX: return to IDLE at that edge, HI/LO unchanged, no done_o, busy_o=0 next cycle.
- flush_i=1 with start_i=1 in IDLE: flush wins and the start is dropped.
- A start accepted in the same cycle that done_o is high (state already IDLE) is legal, giving back-to-back ops.
- Width rules: all arithmetic is unsigned on magnitudes. Negation is two's complement, modulo 2*XLEN for the product and XLEN for quotient/remainder.

Decomposition:
- Package muldiv_pkg holds:
  - op encoding localparams (OP_MULT..OP_MTLO);
  - state enum (IDLE, MUL, DIV, FIX);
  - width-independent helper function abs_val.
- One natural sub-module, muldiv_step: the combinational single-iteration datapath (shift-add / shift-subtract, XLEN-parametrised), instantiated once in the sequencing FSM.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after edge 33: HI=0xFFFFFFFE, LO=0x00000001, done_o pulses exactly once, busy_o high for 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=7, b=0 -> next edge HI=0x00000007, LO=0xFFFFFFFF, done_o pulse. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload MTHI 0x1234, MTLO 0x5678; start DIV; flush_i at cycle 10 -> no done_o, HI=0x1234, LO=0x5678, busy_o=0 next cycle. MTLO/start issued during busy are ignored.
- rst asserted mid-MUL at cycle 5 -> next edge hi_o=lo_o=0, busy_o=0, done_o=0. A subsequent MULTU 6*7 gives LO=42, HI=0.
- XLEN=8 build: MULT 0x80 * 0x80 -> HI=0x40, LO=0x00 after edge 9. Back-to-back DIVU 200/7 started in the done_o cycle -> LO=28, HI=4.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcode
// encodings, sequencer states and the magnitude helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Widest operand the helper can handle; the unit zero-extends into it.
    localparam int MAX_XLEN = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Magnitude of a w-bit two's complement value held in the low w bits of v.
    // The most-negative value maps to itself, read as an unsigned magnitude.
    function automatic logic [MAX_XLEN-1:0] abs_val(input logic [MAX_XLEN-1:0] v,
                                                    input int w);
        logic [MAX_XLEN-1:0] mask;
        logic [MAX_XLEN-1:0] sign_sh;
        mask    = {MAX_XLEN{1'b1}} >> (MAX_XLEN - w);
        sign_sh = v >> (w - 1);
        if (sign_sh[0])
            abs_val = (~v + MAX_XLEN'(1)) & mask;
        else
            abs_val = v & mask;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(parameter int XLEN = 32);

    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;

    // Pipeline side: issues operations, watches busy/done and reads HI/LO.
    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    // Unit side.
    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output busy_o, done_o, hi_o, lo_o
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a radix-2 shift-add multiply step
// or a restoring shift-subtract divide step on a 2*XLEN accumulator.
// Multiply: acc = {partial high, remaining multiplier bits}, operand = multiplicand.
// Divide:   acc = {partial remainder, remaining dividend/quotient bits}, operand = divisor.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] div_next;

    // Multiplicand gated by the current multiplier LSB.
    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_addend
            assign addend[gi] = operand[gi] & acc[0];
        end
    endgenerate

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // Remainder shifted left with the next dividend bit; the top bit of the
    // difference is the borrow that decides whether to restore.
    assign rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign diff      = rem_shift - {1'b0, operand};
    assign div_next  = diff[XLEN] ? {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                  : {diff[XLEN-1:0],      acc[XLEN-2:0], 1'b1};

    assign acc_next = is_div ? div_next : mul_next;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Mul/div run XLEN iterations on unsigned magnitudes followed by one sign
// fix-up cycle; MTHI/MTLO write directly from IDLE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst,
    muldiv_if.slave   bus
);

    localparam int CNT_W = $clog2(XLEN + 1);

    state_t            state_reg,   state_next;
    logic [CNT_W-1:0]  cnt_reg,     cnt_next;
    logic [2*XLEN-1:0] acc_reg,     acc_next;
    logic [XLEN-1:0]   opnd_reg,    opnd_next;
    logic              is_div_reg,  is_div_next;
    logic              neg_res_reg, neg_res_next;
    logic              neg_rem_reg, neg_rem_next;
    logic              dz_reg,      dz_next;
    logic              busy_reg,    busy_next;
    logic              done_reg,    done_next;
    logic [XLEN-1:0]   hi_reg,      hi_next;
    logic [XLEN-1:0]   lo_reg,      lo_next;

    logic              is_signed;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc      (acc_reg),
        .operand  (opnd_reg),
        .is_div   (is_div_reg),
        .acc_next (step_acc)
    );

    // Operand magnitudes and sign flags for the op being issued.
    always_comb begin
        is_signed = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
        sign_a    = is_signed & bus.a_i[XLEN-1];
        sign_b    = is_signed & bus.b_i[XLEN-1];
        mag_a     = is_signed ? XLEN'(abs_val(MAX_XLEN'(bus.a_i), XLEN)) : bus.a_i;
        mag_b     = is_signed ? XLEN'(abs_val(MAX_XLEN'(bus.b_i), XLEN)) : bus.b_i;
    end

    // Sign fix-up of the finished magnitudes.
    always_comb begin
        prod_fix = neg_res_reg ? (~acc_reg + (2*XLEN)'(1)) : acc_reg;
        quot_fix = neg_res_reg ? (~acc_reg[XLEN-1:0] + XLEN'(1)) : acc_reg[XLEN-1:0];
        rem_fix  = neg_rem_reg ? (~acc_reg[2*XLEN-1:XLEN] + XLEN'(1)) : acc_reg[2*XLEN-1:XLEN];
    end

    // Sequencer next-state and datapath control.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        opnd_next    = opnd_reg;
        is_div_next  = is_div_reg;
        neg_res_next = neg_res_reg;
        neg_rem_next = neg_rem_reg;
        dz_next      = dz_reg;
        done_next    = 1'b0;
        hi_next      = hi_reg;
        lo_next      = lo_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    case (bus.op_i)
                        OP_MULT, OP_MULTU: begin
                            acc_next     = {{XLEN{1'b0}}, mag_b};
                            opnd_next    = mag_a;
                            is_div_next  = 1'b0;
                            neg_res_next = sign_a ^ sign_b;
                            neg_rem_next = 1'b0;
                            dz_next      = 1'b0;
                            cnt_next     = '0;
                            state_next   = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            is_div_next  = 1'b1;
                            neg_res_next = sign_a ^ sign_b;
                            neg_rem_next = sign_a;
                            cnt_next     = '0;
                            if (bus.b_i == '0) begin
                                // Divide by zero skips iteration: HI=dividend, LO=all ones.
                                acc_next   = {bus.a_i, {XLEN{1'b1}}};
                                dz_next    = 1'b1;
                                state_next = FIX;
                            end else begin
                                acc_next   = {{XLEN{1'b0}}, mag_a};
                                opnd_next  = mag_b;
                                dz_next    = 1'b0;
                                state_next = DIV;
                            end
                        end
                        OP_MTHI: hi_next = bus.a_i;
                        OP_MTLO: lo_next = bus.a_i;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (bus.flush_i) begin
                    state_next = IDLE;
                end else begin
                    acc_next = step_acc;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(XLEN - 1))
                        state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
                if (!bus.flush_i) begin
                    done_next = 1'b1;
                    if (dz_reg) begin
                        hi_next = acc_reg[2*XLEN-1:XLEN];
                        lo_next = acc_reg[XLEN-1:0];
                    end else if (is_div_reg) begin
                        hi_next = rem_fix;
                        lo_next = quot_fix;
                    end else begin
                        hi_next = prod_fix[2*XLEN-1:XLEN];
                        lo_next = prod_fix[XLEN-1:0];
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and architectural register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            dz_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            opnd_reg    <= opnd_next;
            is_div_reg  <= is_div_next;
            neg_res_reg <= neg_res_next;
            neg_rem_reg <= neg_rem_next;
            dz_reg      <= dz_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    assign bus.busy_o = busy_reg;
    assign bus.done_o = done_reg;
    assign bus.hi_o   = hi_reg;
    assign bus.lo_o   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit and an 8-bit instance share clock and
// reset; results are compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_mis = 0;

    // Architectural HI/LO as the model expects them: index 0 = 32-bit, 1 = 8-bit.
    logic [31:0] mhi [2];
    logic [31:0] mlo [2];

    muldiv_if #(.XLEN(32)) b32 ();
    muldiv_if #(.XLEN(8))  b8 ();

    muldiv_unit #(.XLEN(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
    muldiv_unit #(.XLEN(8))  u8  (.clk(clk), .rst(rst), .bus(b8));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s8, input bit st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input bit fl);
        if (s8) begin
            b8.start_i = st; b8.op_i = op; b8.a_i = a[7:0]; b8.b_i = b[7:0]; b8.flush_i = fl;
        end else begin
            b32.start_i = st; b32.op_i = op; b32.a_i = a; b32.b_i = b; b32.flush_i = fl;
        end
    endtask

    task automatic sample(input bit s8, output bit bz, output bit dn,
                          output logic [31:0] h, output logic [31:0] l);
        if (s8) begin
            bz = b8.busy_o; dn = b8.done_o; h = {24'h0, b8.hi_o}; l = {24'h0, b8.lo_o};
        end else begin
            bz = b32.busy_o; dn = b32.done_o; h = b32.hi_o; l = b32.lo_o;
        end
    endtask

    // Reference: interpret operands as w-bit integers and use ordinary
    // 64-bit arithmetic; SV division truncates toward zero and the remainder
    // follows the dividend, matching MIPS semantics.
    task automatic model(input int w, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] h, output logic [31:0] l);
        longint m, ua, ub, sa, sb, p, q, r;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = (ua >= (longint'(1) << (w - 1))) ? ua - (m + 1) : ua;
        sb = (ub >= (longint'(1) << (w - 1))) ? ub - (m + 1) : ub;
        h = 32'h0; l = 32'h0;
        case (op)
            3'd0, 3'd1: begin
                p = (op == 3'd0) ? sa * sb : ua * ub;
                l = 32'(p & m);
                h = 32'((p >> w) & m);
            end
            3'd2, 3'd3: begin
                if (ub == 0) begin
                    h = 32'(ua);
                    l = 32'(m);
                end else begin
                    q = (op == 3'd2) ? sa / sb : ua / ub;
                    r = (op == 3'd2) ? sa % sb : ua % ub;
                    l = 32'(q & m);
                    h = 32'(r & m);
                end
            end
            default: ;
        endcase
    endtask

    // Issue one op, follow it to completion and check latency, pulse and HI/LO.
    task automatic run_op(input bit s8, input logic [2:0] op, input logic [31:0] a_in,
                          input logic [31:0] b_in, input string tag,
                          output logic [31:0] ohi, output logic [31:0] olo);
        int w = s8 ? 8 : 32;
        int idx = s8 ? 1 : 0;
        logic [31:0] msk = s8 ? 32'hFF : 32'hFFFF_FFFF;
        logic [31:0] a, b, eh, el, h, l;
        int lat, bc, cyc;
        bit bz, dn;
        a = a_in & msk;
        b = b_in & msk;
        eh = mhi[idx];
        el = mlo[idx];
        lat = 0;
        case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                model(w, op, a, b, eh, el);
                lat = (op >= 3'd2 && b == 32'h0) ? 1 : w + 1;
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
        @(negedge clk);
        drive(s8, 1'b1, op, a, b, 1'b0);
        @(negedge clk);
        drive(s8, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        sample(s8, bz, dn, h, l);
        if (lat == 0) begin
            check($sformatf("%s_busy", tag), 64'(bz), 64'(0));
            check($sformatf("%s_done", tag), 64'(dn), 64'(0));
        end else begin
            bc = 0;
            cyc = 0;
            while (!dn && cyc < 200) begin
                if (bz) bc++;
                @(negedge clk);
                sample(s8, bz, dn, h, l);
                cyc++;
            end
            check($sformatf("%s_done", tag), 64'(dn), 64'(1));
            check($sformatf("%s_busycycles", tag), 64'(bc), 64'(lat));
        end
        check($sformatf("%s_hi", tag), 64'(h), 64'(eh));
        check($sformatf("%s_lo", tag), 64'(l), 64'(el));
        $display("op w=%0d %s op=%0d a=%h b=%h -> hi=%h lo=%h", w, tag, op, a, b, h, l);
        mhi[idx] = eh;
        mlo[idx] = el;
        ohi = h;
        olo = l;
        if (lat != 0) begin
            @(negedge clk);
            sample(s8, bz, dn, h, l);
            check($sformatf("%s_donepulse", tag), 64'(dn), 64'(0));
        end
    endtask

    initial begin
        logic [31:0] h, l, ra, rb;
        logic [2:0] rop;
        bit bz, dn, dn_seen;
        int bc, cyc;

        mhi[0] = 32'h0; mlo[0] = 32'h0; mhi[1] = 32'h0; mlo[1] = 32'h0;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sample(1'b0, bz, dn, h, l);
        check("rst_busy", 64'(bz), 64'(0));
        check("rst_done", 64'(dn), 64'(0));
        check("rst_hi", 64'(h), 64'(0));
        check("rst_lo", 64'(l), 64'(0));

        // Directed 32-bit cases
        run_op(1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", h, l);
        check("multu_max_hi_const", 64'(h), 64'h0000_0000_FFFF_FFFE);
        check("multu_max_lo_const", 64'(l), 64'h0000_0000_0000_0001);
        run_op(1'b0, 3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg", h, l);
        check("mult_neg_lo_const", 64'(l), 64'h0000_0000_FFFF_FFEB);
        run_op(1'b0, 3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg", h, l);
        check("div_neg_lo_const", 64'(l), 64'h0000_0000_FFFF_FFFD);
        check("div_neg_hi_const", 64'(h), 64'h0000_0000_FFFF_FFFF);
        run_op(1'b0, 3'd3, 32'd7, 32'd0, "divu_zero", h, l);
        check("divu_zero_lo_const", 64'(l), 64'h0000_0000_FFFF_FFFF);
        run_op(1'b0, 3'd2, 32'hFFFF_FFF9, 32'd0, "div_zero", h, l);
        run_op(1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", h, l);
        check("div_ovf_lo_const", 64'(l), 64'h0000_0000_8000_0000);
        check("div_ovf_hi_const", 64'(h), 64'h0);

        // Flush mid-divide; MTLO and a start issued while busy are ignored
        run_op(1'b0, 3'd4, 32'h1234, 32'h0, "mthi", h, l);
        run_op(1'b0, 3'd5, 32'h5678, 32'h0, "mtlo", h, l);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd2, 32'd1000, 32'd3, 1'b0);
        dn_seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            sample(1'b0, bz, dn, h, l);
            dn_seen |= dn;
            case (i)
                3: drive(1'b0, 1'b1, 3'd5, 32'hDEAD, 32'h0, 1'b0);
                5: drive(1'b0, 1'b1, 3'd1, 32'd5, 32'd5, 1'b0);
                10: drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
                default: drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
            endcase
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        sample(1'b0, bz, dn, h, l);
        check("flush_busy", 64'(bz), 64'(0));
        check("flush_hi", 64'(h), 64'h1234);
        check("flush_lo", 64'(l), 64'h5678);
        repeat (40) begin
            @(negedge clk);
            sample(1'b0, bz, dn, h, l);
            dn_seen |= dn;
        end
        check("flush_nodone", 64'(dn_seen), 64'(0));
        check("flush_lo_after", 64'(l), 64'h5678);
        $display("flush: hi=%h lo=%h done_seen=%0d", h, l, dn_seen);

        // Reset in the middle of a multiply
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd3, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sample(1'b0, bz, dn, h, l);
        check("midrst_busy", 64'(bz), 64'(0));
        check("midrst_done", 64'(dn), 64'(0));
        check("midrst_hi", 64'(h), 64'(0));
        check("midrst_lo", 64'(l), 64'(0));
        $display("midrst: busy=%0d hi=%h lo=%h", bz, h, l);
        mhi[0] = 32'h0; mlo[0] = 32'h0; mhi[1] = 32'h0; mlo[1] = 32'h0;
        run_op(1'b0, 3'd1, 32'd6, 32'd7, "multu_6x7", h, l);
        check("multu_6x7_lo_const", 64'(l), 64'd42);

        // 8-bit: MULT 0x80*0x80 then DIVU 200/7 started in the done cycle
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd0, 32'h80, 32'h80, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        bc = 0; cyc = 0;
        sample(1'b1, bz, dn, h, l);
        while (!dn && cyc < 200) begin
            if (bz) bc++;
            @(negedge clk);
            sample(1'b1, bz, dn, h, l);
            cyc++;
        end
        check("b2b_mult_done", 64'(dn), 64'(1));
        check("b2b_mult_busycycles", 64'(bc), 64'(9));
        check("b2b_mult_hi", 64'(h), 64'h40);
        check("b2b_mult_lo", 64'(l), 64'h00);
        $display("b2b mult8: hi=%h lo=%h busy_cycles=%0d", h, l, bc);
        drive(1'b1, 1'b1, 3'd3, 32'd200, 32'd7, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        cyc = 0;
        sample(1'b1, bz, dn, h, l);
        check("b2b_divu_busy", 64'(bz), 64'(1));
        while (!dn && cyc < 200) begin
            @(negedge clk);
            sample(1'b1, bz, dn, h, l);
            cyc++;
        end
        check("b2b_divu_done", 64'(dn), 64'(1));
        check("b2b_divu_lo", 64'(l), 64'd28);
        check("b2b_divu_hi", 64'(h), 64'd4);
        $display("b2b divu8: hi=%h lo=%h", h, l);
        mhi[1] = 32'd4; mlo[1] = 32'd28;

        // Randomised ops on both widths
        for (int i = 0; i < 25; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            run_op(1'b0, rop, ra, rb, $sformatf("rnd32_%0d", i), h, l);
        end
        for (int i = 0; i < 25; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            run_op(1'b1, rop, ra, rb, $sformatf("rnd8_%0d", i), h, l);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
